ram_true_dual: RTL and testbench



---
 rtl/ram_true_dual.sv | 88 ++++++++
 tb/tb_ram_true_dual.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ram_true_dual.sv
// ----------------------------------------------------------------------------
// ram_true_dual
// True dual-port synchronous RAM. Two independent read/write ports share one
// clock and one storage array. Each port has a registered read data output.
//
// Ports:
//   q1, q2   [DATA_WIDTH-1:0] out  registered read data, port 1 / port 2
//   d1, d2   [DATA_WIDTH-1:0] in   write data, port 1 / port 2
//   a1, a2   [ADDR_WIDTH-1:0] in   address, port 1 / port 2
//   we1, we2                  in   write enable, active high
//   clk                       in   clock, rising-edge active
//   rst_n                     in   asynchronous active-low reset
//                                  (clears q1/q2 only, storage is kept)
//
// Port behaviour on each rising edge with rst_n high:
//   write: mem[a] <= d, q <= d        (write-first on the writing port)
//   read : q <= mem[a]                (one cycle latency)
// Same-address collisions:
//   both write      -> port 1 data is stored
//   write vs. read  -> the reading port sees the pre-edge contents
// ----------------------------------------------------------------------------
module ram_true_dual #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    output logic [DATA_WIDTH-1:0] q1,
    output logic [DATA_WIDTH-1:0] q2,
    input  logic [DATA_WIDTH-1:0] d1,
    input  logic [DATA_WIDTH-1:0] d2,
    input  logic [ADDR_WIDTH-1:0] a1,
    input  logic [ADDR_WIDTH-1:0] a2,
    input  logic                  we1,
    input  logic                  we2,
    input  logic                  clk,
    input  logic                  rst_n
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage array; never reset so power-up contents stay undefined.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] q1_q;
    logic [DATA_WIDTH-1:0] q2_q;
    logic [DATA_WIDTH-1:0] q1_d;
    logic [DATA_WIDTH-1:0] q2_d;
    logic                  wr2_en;

    // Next read data: the writing port forwards its own write data, a reading
    // port samples the array before this edge's writes land.
    always_comb begin
        q1_d = we1 ? d1 : mem[a1];
        q2_d = we2 ? d2 : mem[a2];
    end

    // Port 2's write is suppressed when port 1 writes the same word, so
    // port 1 always wins a double-write collision.
    always_comb begin
        wr2_en = we2 && !(we1 && (a1 == a2));
    end

    // Array writes. Edges seen while rst_n is low perform no write.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (we1) begin
                mem[a1] <= d1;
            end
            if (wr2_en) begin
                mem[a2] <= d2;
            end
        end
    end

    // Output registers clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
        end
    end

    assign q1 = q1_q;
    assign q2 = q2_q;

endmodule

// File: tb/tb_ram_true_dual.sv
// ----------------------------------------------------------------------------
// tb_ram_true_dual
// Self-checking bench for ram_true_dual. A reference model (plain array plus
// a written-flag per word) predicts read data from the port rules: a writing
// port returns its own data, a reading port returns the pre-edge contents,
// and on a double write to one word port 1's data is kept.
// ----------------------------------------------------------------------------
module tb_ram_true_dual;

    logic [7:0] q1, q2, d1, d2;
    logic [6:0] a1, a2;
    logic       we1, we2;
    logic       clk;
    logic       rst_n;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem   [128];
    bit         ref_valid [128];

    ram_true_dual #(.DATA_WIDTH(8), .ADDR_WIDTH(7)) dut (
        .q1   (q1),
        .q2   (q2),
        .d1   (d1),
        .d2   (d2),
        .a1   (a1),
        .a2   (a2),
        .we1  (we1),
        .we2  (we2),
        .clk  (clk),
        .rst_n(rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one transaction, predict both read results from the model, take
    // one clock edge and update the model. Returns with time 1 past the edge.
    task automatic apply(input logic w1, input logic [6:0] ad1, input logic [7:0] da1,
                         input logic w2, input logic [6:0] ad2, input logic [7:0] da2,
                         output logic [7:0] e1, output logic [7:0] e2,
                         output bit v1, output bit v2);
        we1 = w1; a1 = ad1; d1 = da1;
        we2 = w2; a2 = ad2; d2 = da2;
        e1 = w1 ? da1 : ref_mem[ad1];
        e2 = w2 ? da2 : ref_mem[ad2];
        v1 = w1 || ref_valid[ad1];
        v2 = w2 || ref_valid[ad2];
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (w2) begin ref_mem[ad2] = da2; ref_valid[ad2] = 1'b1; end
            if (w1) begin ref_mem[ad1] = da1; ref_valid[ad1] = 1'b1; end
        end
        $display("txn t=%0t we1=%b a1=%h d1=%h q1=%h | we2=%b a2=%h d2=%h q2=%h",
                 $time, w1, ad1, da1, q1, w2, ad2, da2, q2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we1 = 1'b0; we2 = 1'b0; a1 = '0; a2 = '0; d1 = '0; d2 = '0;
        #1;
        checks++;
        if (q1 !== 8'h00) begin errors++; $display("FAIL reset_q1 got %h expected %h", q1, 8'h00); end
        checks++;
        if (q2 !== 8'h00) begin errors++; $display("FAIL reset_q2 got %h expected %h", q2, 8'h00); end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (q1 !== 8'h00 || q2 !== 8'h00) begin
            errors++; $display("FAIL reset_hold got q1=%h q2=%h expected 00 00", q1, q2);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [7:0] e1, e2; bit v1, v2;
        apply(1'b1, 7'h7F, 8'h55, 1'b1, 7'h55, 8'hFF, e1, e2, v1, v2);
        apply(1'b0, 7'h7F, 8'h00, 1'b0, 7'h55, 8'h00, e1, e2, v1, v2);
        checks++;
        if (q1 !== 8'h55) begin errors++; $display("FAIL wr_rd_q1 got %h expected %h", q1, 8'h55); end
        checks++;
        if (q2 !== 8'hFF) begin errors++; $display("FAIL wr_rd_q2 got %h expected %h", q2, 8'hFF); end
    endtask

    task automatic test_pattern2();
        logic [7:0] e1, e2; bit v1, v2;
        apply(1'b1, 7'h00, 8'hF0, 1'b1, 7'h2A, 8'h00, e1, e2, v1, v2);
        apply(1'b0, 7'h00, 8'h00, 1'b0, 7'h2A, 8'h00, e1, e2, v1, v2);
        checks++;
        if (q1 !== 8'hF0) begin errors++; $display("FAIL pat2_q1 got %h expected %h", q1, 8'hF0); end
        checks++;
        if (q2 !== 8'h00) begin errors++; $display("FAIL pat2_q2 got %h expected %h", q2, 8'h00); end
        apply(1'b0, 7'h7F, 8'h00, 1'b0, 7'h55, 8'h00, e1, e2, v1, v2);
        checks++;
        if (q1 !== 8'h55 || q2 !== 8'hFF) begin
            errors++; $display("FAIL pat2_reread got q1=%h q2=%h expected 55 FF", q1, q2);
        end
    endtask

    task automatic test_write_first();
        logic [7:0] e1, e2; bit v1, v2;
        apply(1'b1, 7'h10, 8'hA5, 1'b0, 7'h00, 8'h00, e1, e2, v1, v2);
        checks++;
        if (q1 !== 8'hA5) begin errors++; $display("FAIL write_first_q1 got %h expected %h", q1, 8'hA5); end
        checks++;
        if (q2 !== 8'hF0) begin errors++; $display("FAIL write_first_q2 got %h expected %h", q2, 8'hF0); end
    endtask

    task automatic test_collisions();
        logic [7:0] e1, e2; bit v1, v2;
        // Both ports write the same word.
        apply(1'b1, 7'h20, 8'h11, 1'b1, 7'h20, 8'h22, e1, e2, v1, v2);
        checks++;
        if (q1 !== 8'h11 || q2 !== 8'h22) begin
            errors++; $display("FAIL coll_ww_edge got q1=%h q2=%h expected 11 22", q1, q2);
        end
        apply(1'b0, 7'h20, 8'h00, 1'b0, 7'h20, 8'h00, e1, e2, v1, v2);
        checks++;
        if (q1 !== 8'h11 || q2 !== 8'h11) begin
            errors++; $display("FAIL coll_ww_read got q1=%h q2=%h expected 11 11", q1, q2);
        end
        // Port 1 writes while port 2 reads the same word.
        apply(1'b0, 7'h00, 8'h00, 1'b1, 7'h30, 8'h33, e1, e2, v1, v2);
        apply(1'b1, 7'h30, 8'h77, 1'b0, 7'h30, 8'h00, e1, e2, v1, v2);
        checks++;
        if (q2 !== 8'h33) begin errors++; $display("FAIL coll_wr_old got %h expected %h", q2, 8'h33); end
        checks++;
        if (q1 !== 8'h77) begin errors++; $display("FAIL coll_wr_q1 got %h expected %h", q1, 8'h77); end
        apply(1'b0, 7'h00, 8'h00, 1'b0, 7'h30, 8'h00, e1, e2, v1, v2);
        checks++;
        if (q2 !== 8'h77) begin errors++; $display("FAIL coll_wr_new got %h expected %h", q2, 8'h77); end
    endtask

    task automatic test_async_reset();
        logic [7:0] e1, e2; bit v1, v2;
        apply(1'b1, 7'h40, 8'h3C, 1'b1, 7'h41, 8'h5A, e1, e2, v1, v2);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (q1 !== 8'h00 || q2 !== 8'h00) begin
            errors++; $display("FAIL async_clear got q1=%h q2=%h expected 00 00", q1, q2);
        end
        // Edge while held in reset: the write must be ignored.
        we1 = 1'b1; a1 = 7'h40; d1 = 8'hCC; we2 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q1 !== 8'h00 || q2 !== 8'h00) begin
            errors++; $display("FAIL reset_edge got q1=%h q2=%h expected 00 00", q1, q2);
        end
        we1 = 1'b0;
        #3 rst_n = 1'b1;
        #1;
        apply(1'b0, 7'h10, 8'h00, 1'b0, 7'h40, 8'h00, e1, e2, v1, v2);
        checks++;
        if (q1 !== 8'hA5) begin errors++; $display("FAIL retain_q1 got %h expected %h", q1, 8'hA5); end
        checks++;
        if (q2 !== 8'h3C) begin errors++; $display("FAIL no_write_in_reset got %h expected %h", q2, 8'h3C); end
    endtask

    task automatic test_random();
        logic [7:0] e1, e2; bit v1, v2;
        logic [6:0] ra1, ra2;
        for (int i = 0; i < 300; i++) begin
            // Narrow address window (plus frequent forced equality) to provoke collisions.
            ra1 = 7'h50 + 7'($urandom_range(0, 7));
            ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 7'h50 + 7'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) ra1 = 7'($urandom_range(0, 127));
            apply(1'($urandom_range(0, 1)), ra1, 8'($urandom),
                  1'($urandom_range(0, 1)), ra2, 8'($urandom), e1, e2, v1, v2);
            if (v1) begin
                checks++;
                if (q1 !== e1) begin errors++; $display("FAIL rand_q1 i=%0d got %h expected %h", i, q1, e1); end
            end
            if (v2) begin
                checks++;
                if (q2 !== e2) begin errors++; $display("FAIL rand_q2 i=%0d got %h expected %h", i, q2, e2); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ref_mem[i]   = 8'h00;
            ref_valid[i] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_pattern2();
        test_write_first();
        test_collisions();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
